// File: rtl/nmr_pio_out_bank.sv
// Multi-channel Avalon-MM output PIO bank with shadow/live registers and atomic commit.
// Define NMR_PIO_PULSE_EN to add PULSE_LEN and per-channel one-shot auto-revert counters.
module nmr_pio_out_bank #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          NUM_CH      = 4,
    parameter logic [31:0] RESET_VALUE = 32'd119
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [3:0]                   address,
    input  logic                         chipselect,
    input  logic                         write_n,
    input  logic [31:0]                  writedata,
    output logic [31:0]                  readdata,
    input  logic                         sync_in,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_port,
    output logic [NUM_CH-1:0]            commit_pulse
);

    localparam logic [DATA_WIDTH-1:0] RST_VAL = RESET_VALUE[DATA_WIDTH-1:0];

    logic [DATA_WIDTH-1:0] shadow [NUM_CH];
    logic [DATA_WIDTH-1:0] live   [NUM_CH];
    logic [NUM_CH-1:0]     arm;
    logic                  sync_d;
    logic                  sync_edge;
    logic                  wr;
    logic [NUM_CH-1:0]     wr_shadow;
    logic [NUM_CH-1:0]     commit;
    logic [NUM_CH-1:0]     dirty;
`ifdef NMR_PIO_PULSE_EN
    logic [15:0]           pulse_len;
    logic [15:0]           cnt [NUM_CH];
`endif

    assign wr        = chipselect && !write_n;
    assign sync_edge = sync_in && !sync_d;

    // Software commit and sync-edge commit merge into one mask, so a coincident pair pulses once.
    assign commit = ({NUM_CH{wr && (address == 4'h8)}} & writedata[NUM_CH-1:0])
                  | ({NUM_CH{sync_edge}} & arm);

    always_comb begin
        wr_shadow = '0;
        dirty     = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            wr_shadow[n] = wr && (address == 4'(n));
            dirty[n]     = (shadow[n] != live[n]);
        end
    end

    always_comb begin
        readdata = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (address == 4'(n))
                readdata[DATA_WIDTH-1:0] = shadow[n];
            if (address == 4'(n + 4))
                readdata[DATA_WIDTH-1:0] = live[n];
        end
        case (address)
            4'h9: readdata[NUM_CH-1:0] = arm;
            4'hA: begin
                readdata[NUM_CH-1:0]  = arm;
                readdata[8 +: NUM_CH] = dirty;
            end
`ifdef NMR_PIO_PULSE_EN
            4'hB: readdata[15:0] = pulse_len;
`endif
            default: ;
        endcase
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign out_port[g*DATA_WIDTH +: DATA_WIDTH] = live[g];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int n = 0; n < NUM_CH; n++) begin
                shadow[n] <= RST_VAL;
                live[n]   <= RST_VAL;
`ifdef NMR_PIO_PULSE_EN
                cnt[n]    <= '0;
`endif
            end
            arm          <= '0;
            sync_d       <= 1'b0;
            commit_pulse <= '0;
`ifdef NMR_PIO_PULSE_EN
            pulse_len    <= '0;
`endif
        end else begin
            sync_d       <= sync_in;
            commit_pulse <= commit;
            // A write replaces the mask; otherwise an edge consumes every armed bit.
            if (wr && (address == 4'h9))
                arm <= writedata[NUM_CH-1:0];
            else if (sync_edge)
                arm <= '0;
`ifdef NMR_PIO_PULSE_EN
            if (wr && (address == 4'hB))
                pulse_len <= writedata[15:0];
`endif
            for (int n = 0; n < NUM_CH; n++) begin
                if (wr_shadow[n])
                    shadow[n] <= writedata[DATA_WIDTH-1:0];
`ifdef NMR_PIO_PULSE_EN
                if (commit[n]) begin
                    live[n] <= shadow[n];
                    cnt[n]  <= pulse_len;
                end else if (cnt[n] != 16'd0) begin
                    cnt[n] <= cnt[n] - 16'd1;
                    if (cnt[n] == 16'd1)
                        live[n] <= RST_VAL;
                end
`else
                if (commit[n])
                    live[n] <= shadow[n];
`endif
            end
        end
    end

endmodule

// File: tb/tb_nmr_pio_out_bank.sv
// Randomized and directed bench for nmr_pio_out_bank against a behavioural register-bank model.
module tb_nmr_pio_out_bank;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [3:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic         sync_in;
    logic [127:0] out_port;
    logic [3:0]   commit_pulse;

    int n_checks = 0;
    int n_errors = 0;

    nmr_pio_out_bank dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .sync_in      (sync_in),
        .out_port     (out_port),
        .commit_pulse (commit_pulse)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_shadow [4];
    logic [31:0] m_live   [4];
    logic [3:0]  m_arm;
    logic [3:0]  m_pulse;
    logic        m_sync_d;
`ifdef NMR_PIO_PULSE_EN
    int          m_cnt [4];
    logic [15:0] m_plen;
`endif

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] m_out();
        return {m_live[3], m_live[2], m_live[1], m_live[0]};
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] a);
        logic [3:0] d;
        for (int i = 0; i < 4; i++) d[i] = (m_shadow[i] != m_live[i]);
        if (a < 4)       return m_shadow[a[1:0]];
        else if (a < 8)  return m_live[a[1:0]];
        else if (a == 9) return {28'd0, m_arm};
        else if (a == 10) return {20'd0, d, 4'd0, m_arm};
`ifdef NMR_PIO_PULSE_EN
        else if (a == 11) return {16'd0, m_plen};
`endif
        return 32'd0;
    endfunction

    task automatic model_clock();
        logic       edge_seen, wr;
        logic [3:0] cm;
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                m_shadow[i] = 32'd119;
                m_live[i]   = 32'd119;
`ifdef NMR_PIO_PULSE_EN
                m_cnt[i]    = 0;
`endif
            end
            m_arm = 0; m_pulse = 0; m_sync_d = 0;
`ifdef NMR_PIO_PULSE_EN
            m_plen = 0;
`endif
            return;
        end
        edge_seen = sync_in && !m_sync_d;
        wr = chipselect && !write_n;
        cm = 4'd0;
        if (wr && address == 4'd8) cm = writedata[3:0];
        if (edge_seen) cm = cm | m_arm;
        for (int i = 0; i < 4; i++) begin
            if (cm[i]) begin
                m_live[i] = m_shadow[i];
`ifdef NMR_PIO_PULSE_EN
                m_cnt[i] = int'(m_plen);
`endif
            end
`ifdef NMR_PIO_PULSE_EN
            else if (m_cnt[i] > 0) begin
                m_cnt[i] = m_cnt[i] - 1;
                if (m_cnt[i] == 0) m_live[i] = 32'd119;
            end
`endif
        end
        if (wr && address < 4) m_shadow[address[1:0]] = writedata;
        if (wr && address == 4'd9) m_arm = writedata[3:0];
        else if (edge_seen) m_arm = 4'd0;
`ifdef NMR_PIO_PULSE_EN
        if (wr && address == 4'd11) m_plen = writedata[15:0];
`endif
        m_pulse  = cm;
        m_sync_d = sync_in;
    endtask

    // One clock: drive inputs, advance the model at the edge, compare all outputs #1 later.
    task automatic cyc(input logic rst, input logic cs, input logic wn, input logic [3:0] a,
                       input logic [31:0] wd, input logic sync);
        reset_n = rst; chipselect = cs; write_n = wn; address = a; writedata = wd; sync_in = sync;
        @(posedge clk);
        model_clock();
        #1;
        check("out_port", out_port, m_out());
        check("commit_pulse", {124'd0, commit_pulse}, {124'd0, m_pulse});
        check("readdata", {96'd0, readdata}, {96'd0, m_read(address)});
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [31:0] wd, input logic sync);
        cyc(1'b1, 1'b1, 1'b0, a, wd, sync);
    endtask

    task automatic idle(input logic [3:0] a, input logic sync);
        cyc(1'b1, 1'b0, 1'b1, a, 32'd0, sync);
    endtask

    initial begin
        reset_n = 0; chipselect = 0; write_n = 1; address = 0; writedata = 0; sync_in = 0;
        m_arm = 0; m_pulse = 0; m_sync_d = 0;

        cyc(1'b0, 1'b0, 1'b1, 4'd4, 32'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 4'd4, 32'd0, 1'b0);
        idle(4'd4, 1'b0);
        check("rst_out_port", out_port, {4{32'd119}});
        check("rst_live0", {96'd0, readdata}, 128'd119);
        check("rst_pulse", {124'd0, commit_pulse}, 128'd0);

        wr_reg(4'd1, 32'hA5, 1'b0);
        idle(4'hA, 1'b0);
        check("status_dirty", {96'd0, readdata}, 128'h200);
        wr_reg(4'h8, 32'h2, 1'b0);
        check("commit_live1", {96'd0, out_port[63:32]}, 128'hA5);
        check("commit_pulse1", {124'd0, commit_pulse}, 128'h2);
        check("commit_others", {out_port[127:64], 32'd0, out_port[31:0]},
              {32'd119, 32'd119, 32'd0, 32'd119});
        idle(4'd5, 1'b0);
        check("pulse_one_cycle", {124'd0, commit_pulse}, 128'd0);

        wr_reg(4'd0, 32'd5, 1'b0);
        wr_reg(4'h9, 32'h1, 1'b0);
        idle(4'h9, 1'b1);
        check("sync_commit0", {96'd0, out_port[31:0]}, 128'd5);
        check("sync_pulse0", {124'd0, commit_pulse}, 128'h1);
        check("arm_cleared", {96'd0, readdata}, 128'd0);
        for (int i = 0; i < 9; i++) idle(4'd4, 1'b1);
        check("level_no_pulse", {124'd0, commit_pulse}, 128'd0);
        wr_reg(4'd0, 32'd6, 1'b1);
        wr_reg(4'h9, 32'h1, 1'b1);
        for (int i = 0; i < 3; i++) idle(4'd4, 1'b1);
        check("level_no_retrigger", {96'd0, out_port[31:0]}, 128'd5);

        idle(4'd0, 1'b0);
        wr_reg(4'd2, 32'h44, 1'b0);
        wr_reg(4'h9, 32'h4, 1'b0);
        wr_reg(4'd2, 32'h33, 1'b1);
        check("same_edge_live2", {96'd0, out_port[95:64]}, 128'h44);
        check("same_edge_shadow2", {96'd0, readdata}, 128'h33);
        check("same_edge_pulse", {124'd0, commit_pulse}, 128'h4);
        wr_reg(4'h8, 32'h4, 1'b1);
        check("second_commit2", {96'd0, out_port[95:64]}, 128'h33);

        idle(4'd0, 1'b0);
        wr_reg(4'h9, 32'hF, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 4'h9, 32'd0, 1'b0);
        check("mid_rst_out", out_port, {4{32'd119}});
        check("mid_rst_arm", {96'd0, readdata}, 128'd0);
        idle(4'h9, 1'b1);
        check("post_rst_sync_pulse", {124'd0, commit_pulse}, 128'd0);
        check("post_rst_sync_out", out_port, {4{32'd119}});

`ifdef NMR_PIO_PULSE_EN
        idle(4'd0, 1'b0);
        wr_reg(4'hB, 32'd3, 1'b0);
        wr_reg(4'd3, 32'hFF, 1'b0);
        wr_reg(4'h8, 32'h8, 1'b0);
        check("oneshot_live3", {96'd0, out_port[127:96]}, 128'hFF);
        check("oneshot_pulse", {124'd0, commit_pulse}, 128'h8);
        for (int i = 0; i < 2; i++) begin
            idle(4'd7, 1'b0);
            check("oneshot_hold", {96'd0, out_port[127:96]}, 128'hFF);
        end
        idle(4'd7, 1'b0);
        check("oneshot_revert", {96'd0, out_port[127:96]}, 128'd119);
        check("oneshot_no_pulse", {124'd0, commit_pulse}, 128'd0);
`endif

        for (int i = 0; i < 3000; i++) begin
            logic [3:0]  a;
            logic [31:0] wd;
            a  = 4'($urandom_range(0, 15));
            wd = $urandom();
            if (a == 4'hB) wd = $urandom_range(0, 6);
            if ($urandom_range(0, 3) == 0) wd = wd & 32'hFF;
            cyc($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                a, wd, $urandom_range(0, 2) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nmr_pio_out_bank.md
Name: nmr_pio_out_bank

Overview:
- Parametrised multi-channel Avalon-MM output PIO bank; successor to the single-register 32-bit output PIO.
- Each channel has a CPU-writable shadow register and a live output register. Shadow is copied to live on a software commit or on a hardware sync edge from the pulse sequencer, so multi-word NMR settings change atomically.
- Sits between the HPS lightweight bridge and the NMR front-end control fabric.

Parameters:
- DATA_WIDTH, 32, width of each channel register (1..32).
- NUM_CH, 4, number of channels (1..4).
- RESET_VALUE, 119, reset value of every shadow and live register.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset, sampled on rising clk.
- address  in  4  Avalon word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data.
- sync_in  in  1  commit trigger from the sequencer, synchronous to clk.
- out_port  out  NUM_CH*DATA_WIDTH  live registers concatenated; channel 0 in the LSBs.
- commit_pulse  out  NUM_CH  one-cycle strobe per channel, asserted in the cycle its live value changes source.

Behaviour:
- Reset: if reset_n=0 at a rising clk edge, the following take their reset values on that edge, overriding any access on the same edge: shadow and live = RESET_VALUE; arm = 0; sync_d = 0; commit_pulse = 0; PULSE_LEN = 0 and counters = 0 (if present). Reset mid-operation drops pending arms and pulses.
- Write condition: chipselect && !write_n. Zero wait states.
- readdata is combinational from address; unused bits and unmapped addresses read 0. Channel fields are zero-extended from DATA_WIDTH to 32.
- Register map:
  - 0x0-0x3: SHADOW[n], RW, writedata[DATA_WIDTH-1:0]. Index n >= NUM_CH: read 0, write ignored.
  - 0x4-0x7: LIVE[n], RO.
  - 0x8: COMMIT, WO, reads 0. Writing bit n=1 commits channel n on that edge.
  - 0x9: ARM, RW. Bits [NUM_CH-1:0] hold the arm mask; a write replaces it.
  - 0xA: STATUS, RO. [NUM_CH-1:0] = arm mask; [8+NUM_CH-1:8] = dirty (SHADOW[n] != LIVE[n]).
  - 0xB: PULSE_LEN, see Optional Feature.
- Sync edge: sync_d registers sync_in. An edge exists when sync_in && !sync_d.
  - On an edge, every armed channel commits and its arm bit clears on the same clk edge.
  - Level-high sync_in does not retrigger.
- Commit: LIVE[n] <= SHADOW[n] value held before the edge. commit_pulse[n] = 1 for exactly that one cycle, registered so it is aligned with the new out_port.
- Latency:
  - COMMIT write at edge k: out_port changes at edge k.
  - sync_in rising before edge k (seen with sync_d=0): out_port changes at edge k.
- Simultaneous events:
  - SHADOW write with a commit of the same channel: live takes the old shadow; shadow takes the new data.
  - COMMIT write with a sync edge: a single commit; commit_pulse is one cycle.
  - ARM write with a sync edge: previously armed channels commit. The arm register takes writedata, so newly set bits wait for the next edge.
- A commit with SHADOW equal to LIVE still pulses commit_pulse.

Optional Feature:
- Macro: NMR_PIO_PULSE_EN.
- With it:
  - PULSE_LEN (0xB) is a 16-bit RW register.
  - Each channel has a 16-bit down-counter. On commit of channel n, its counter loads PULSE_LEN.
  - While the counter is nonzero it decrements each cycle. On the 1->0 transition, LIVE[n] <= RESET_VALUE with no commit_pulse, giving a one-shot output.
  - PULSE_LEN=0: no auto-revert.
  - A new commit during a countdown reloads the counter.
- Without it: 0xB reads 0, writes are ignored, no counters exist, and live values hold indefinitely.

Test Plan:
- Reset released: out_port = {4{32'd119}}, readdata at 0x4 = 119, commit_pulse = 0.
- Write SHADOW[1]=0xA5, read 0xA = 0x0200 (dirty bit 9). Write 0x8=0x2: at that edge LIVE[1] = 0xA5, commit_pulse = 4'b0010 for 1 cycle, channels 0, 2 and 3 stay 119.
- Write SHADOW[0]=5, ARM=0x1, hold sync_in=1 for 10 cycles: single commit to 5 at the edge after the rise, ARM reads 0. Write SHADOW[0]=6 and re-arm with sync_in still high: no further commit.
- SHADOW[2] write of 0x33 on the same cycle as COMMIT bit 2: LIVE[2] = old shadow. A second COMMIT gives 0x33.
- Assert reset_n=0 for one cycle while ARM=0xF: all registers return to 119, ARM = 0, a later sync edge causes no commit.
- With NMR_PIO_PULSE_EN, PULSE_LEN=3, commit channel 3 to 0xFF: LIVE[3] = 0xFF for 3 cycles, then 119, no extra commit_pulse.
